// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: pointer width default and Gray/binary helpers.
// The helpers work on a wide word. Callers zero-extend their pointer into it
// and cast the result back down. Zero upper bits leave both conversions
// correct for any pointer width up to FIFO_PTR_MAX.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH_DEF = 4;
  localparam int FIFO_PTR_MAX       = 32;

  typedef logic [FIFO_PTR_MAX-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    bin[FIFO_PTR_MAX-1] = gray[FIFO_PTR_MAX-1];
    for (int i = FIFO_PTR_MAX-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_nff.sv
// N-flop synchronizer for a Gray pointer crossing into this clock domain.
// All stages reset to zero. Stage 0 samples the foreign-domain input.
module fifo_sync_nff #(
  parameter int width  = 4,
  parameter int stages = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  logic [stages-1:0][width-1:0] r_sync;

  // Shift the sampled pointer one stage deeper on every clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[stages-2:0], i_d};
  end

  assign o_q = r_sync[stages-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic of the async FIFO (w_clk domain).
// The binary and Gray write pointers update together, so they never disagree.
// Full, almost-full and level come from registers and the synchronized read
// pointer only. A stale read pointer can make them pessimistic, never optimistic.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ptr_width   = FIFO_PTR_WIDTH_DEF,
  parameter int sync_stages = 2,
  parameter int af_margin   = 1
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 w_inc,
  input  logic [ptr_width-1:0] gray_r_ptr,
  input  logic                 w_ovf_clr,
  output logic                 w_en,
  output logic [ptr_width-2:0] w_addr,
  output logic [ptr_width-1:0] gray_w_ptr,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [ptr_width-1:0] w_count,
  output logic                 w_overflow
);

  localparam int DEPTH = 1 << (ptr_width-1);

  typedef logic [ptr_width-1:0] ptr_t;

  // Full when the write pointer is one lap ahead. In Gray code this means
  // the top two bits are inverted and the remaining bits are equal.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (ptr_width-2);
  localparam ptr_t AF_LEVEL  = ptr_t'(DEPTH - af_margin);

  ptr_t r_w_ptr;
  ptr_t r_gray_w_ptr;
  logic r_overflow;

  ptr_t w_sync_r_ptr;
  ptr_t w_rd_bin;
  ptr_t w_ptr_nxt;
  ptr_t w_gray_nxt;
  ptr_t w_level;
  logic w_is_full;
  logic w_accept;

  fifo_sync_nff #(
    .width  (ptr_width),
    .stages (sync_stages)
  ) u_sync_r_ptr (
    .i_clk   (w_clk),
    .i_rst_n (w_rst_n),
    .i_d     (gray_r_ptr),
    .o_q     (w_sync_r_ptr)
  );

  assign w_ptr_nxt  = r_w_ptr + ptr_t'(1);
  assign w_gray_nxt = ptr_t'(bin2gray(ptr_word_t'(w_ptr_nxt)));
  assign w_rd_bin   = ptr_t'(gray2bin(ptr_word_t'(w_sync_r_ptr)));
  assign w_level    = r_w_ptr - w_rd_bin;
  assign w_is_full  = (r_gray_w_ptr == (w_sync_r_ptr ^ FULL_MASK));
  assign w_accept   = w_inc && !w_is_full;

  // Advance the binary and Gray pointers together on every accepted write.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_w_ptr      <= '0;
      r_gray_w_ptr <= '0;
    end else if (w_accept) begin
      r_w_ptr      <= w_ptr_nxt;
      r_gray_w_ptr <= w_gray_nxt;
    end
  end

  // Sticky overflow. A refused write takes priority over a same-cycle clear.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n)                r_overflow <= 1'b0;
    else if (w_inc && w_is_full) r_overflow <= 1'b1;
    else if (w_ovf_clr)          r_overflow <= 1'b0;
  end

  // Keep the write strobe low for the whole time reset is held, even with
  // w_inc asserted, so the memory sees no write during reset.
  assign w_en          = w_accept && w_rst_n;
  assign w_addr        = r_w_ptr[ptr_width-2:0];
  assign gray_w_ptr    = r_gray_w_ptr;
  assign w_full        = w_is_full;
  assign w_count       = w_level;
  assign w_almost_full = (w_level >= AF_LEVEL);
  assign w_overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full. The driver keeps absolute write and
// read counts as plain integers and pushes the expected outputs for each cycle.
// A separate monitor pops each expectation and compares it with the DUT.
module tb_fifo_wptr_full;

  localparam int PW    = 4;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int AFM   = 1;

  logic          w_clk = 1'b0;
  logic          w_rst_n = 1'b0;
  logic          w_inc = 1'b0;
  logic          w_ovf_clr = 1'b0;
  logic [PW-1:0] gray_r_ptr = '0;
  logic          w_en;
  logic [PW-2:0] w_addr;
  logic [PW-1:0] gray_w_ptr;
  logic          w_full;
  logic          w_almost_full;
  logic [PW-1:0] w_count;
  logic          w_overflow;

  fifo_wptr_full #(.ptr_width(PW), .sync_stages(SYNC), .af_margin(AFM)) dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .w_inc         (w_inc),
    .gray_r_ptr    (gray_r_ptr),
    .w_ovf_clr     (w_ovf_clr),
    .w_en          (w_en),
    .w_addr        (w_addr),
    .gray_w_ptr    (gray_w_ptr),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_count       (w_count),
    .w_overflow    (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic          en;
    logic [PW-2:0] addr;
    logic [PW-1:0] gw;
    logic          full;
    logic          af;
    logic [PW-1:0] cnt;
    logic          ovf;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: total writes accepted, total reads done, and the read count as the
  // write side sees it (delayed by SYNC write-clock edges).
  int m_w = 0;
  int m_r = 0;
  int m_dl[SYNC];
  bit m_ovf = 1'b0;

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (1 << PW));
    return b ^ (b >> 1);
  endfunction

  // One write-clock cycle: drive the inputs at negedge, post the expectation,
  // then apply the effect of the coming rising edge to the model.
  task automatic step(input bit rst_n, input bit inc, input bit radv, input bit clr);
    obs_t e;
    int   lvl;
    bit   full;
    @(negedge w_clk);
    if (!rst_n) begin
      m_w = 0;
      m_r = 0;
      m_ovf = 1'b0;
      for (int i = 0; i < SYNC; i++) m_dl[i] = 0;
    end else if (radv && m_r < m_w) begin
      m_r++;
    end
    w_rst_n    = rst_n;
    w_inc      = inc;
    w_ovf_clr  = clr;
    gray_r_ptr = gray_of(m_r);
    lvl  = m_w - m_dl[SYNC-1];
    full = (lvl == DEPTH);
    e.en   = rst_n && inc && !full;
    e.addr = (PW-1)'(m_w % DEPTH);
    e.gw   = gray_of(m_w);
    e.full = full;
    e.af   = (lvl >= DEPTH - AFM);
    e.cnt  = PW'(lvl);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    if (rst_n) begin
      if (inc && !full) m_w++;
      if (inc && full) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
      for (int i = SYNC-1; i > 0; i--) m_dl[i] = m_dl[i-1];
      m_dl[0] = m_r;
    end
  endtask

  // Monitor: the DUT presents a settled output every cycle, 2 time units
  // after the falling edge that drove the inputs.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge w_clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{w_en, w_addr, gray_w_ptr, w_full, w_almost_full, w_count, w_overflow};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs vec %0d t=%0t: got en=%b addr=%0d gw=%b full=%b af=%b cnt=%0d ovf=%b, want en=%b addr=%0d gw=%b full=%b af=%b cnt=%0d ovf=%b",
                   vectors, $time, a.en, a.addr, a.gw, a.full, a.af, a.cnt, a.ovf,
                   e.en, e.addr, e.gw, e.full, e.af, e.cnt, e.ovf);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < SYNC; i++) m_dl[i] = 0;
    // Reset held with a write request pending.
    repeat (3) step(0, 1, 0, 0);
    // Fill from empty with the read pointer parked at zero.
    repeat (DEPTH) step(1, 1, 0, 0);
    // Overflow, clear colliding with a refused write, then a lone clear.
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    // One read: level must still read full for two edges, then drop to 7.
    step(1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    // Drain down to a low level, then stream writes across the pointer wrap.
    repeat (12) step(1, 0, 1, 0);
    for (int n = 0; n < 30; n++) step(1, 1, (m_w - m_r) >= 3, 0);
    // Reset in the middle of operation at a level of 5, then refill.
    step(0, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (DEPTH + 2) step(1, 1, 0, 0);
    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step(1, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 10);
    end
    step(1, 0, 0, 0);
    @(negedge w_clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
